// File: rtl/cpu_types_pkg.sv
// Core-wide types: hazard FSM states and the shadow-pipeline writer record.
package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_ISTALL = 2'd1,
        HZ_DSTALL = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             is_load;
    } shadow_slot_t;

endpackage

// File: rtl/data_path_muxs_pkg.sv
// PC source select encoding shared by the fetch mux and the hazard controller.
package data_path_muxs_pkg;

    typedef enum logic [2:0] {
        SEL_NXT     = 3'd0,
        SEL_BR_TGT  = 3'd1,
        SEL_JMP     = 3'd2,
        SEL_JR      = 3'd3,
        SEL_RESOLVE = 3'd4
    } pc_sel_t;

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Tracks in-flight register writers from EX onwards and reports which of them
// the ID instruction must wait for.
module hazard_shadow_pipe
    import cpu_types_pkg::*;
#(
    parameter int STAGES        = 5,
    parameter int RESOLVE_STAGE = 3,
    parameter int LOAD_LAT      = 1,
    parameter int FWD_EN        = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             shift,
    input  logic             kill,
    input  logic             ins_valid,
    input  logic [REG_W-1:0] ins_reg,
    input  logic             ins_is_load,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             rs_used,
    input  logic             rt_used,
    output logic [STAGES-3:0] block_vec
);

    localparam int NENT = STAGES - 2;

    shadow_slot_t slots [NENT];

    // Slots younger than the resolve stage belong to the wrong path on a mispredict.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < NENT; k++) slots[k] <= '0;
        end else if (shift) begin
            slots[0] <= '{valid: ins_valid, rd: ins_reg, is_load: ins_is_load};
            for (int k = 1; k < NENT; k++) begin
                if (kill && k <= RESOLVE_STAGE - 2) slots[k] <= '0;
                else                                slots[k] <= slots[k-1];
            end
        end
    end

    always_comb begin
        block_vec = '0;
        for (int k = 0; k < NENT; k++) begin
            block_vec[k] = slots[k].valid && (slots[k].rd != '0)
                && ((rs_used && rs == slots[k].rd) || (rt_used && rt == slots[k].rd))
                && ((FWD_EN != 0) ? (slots[k].is_load && k < LOAD_LAT) : (k < NENT - 1));
        end
    end

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Hazard controller for an N-stage in-order pipeline: memory-wait freeze,
// load-use/RAW stalls, mispredict recovery, decode redirects and a stall counter.
module hazard_ctrl_sb
    import cpu_types_pkg::*;
    import data_path_muxs_pkg::*;
#(
    parameter int STAGES        = 5,
    parameter int RESOLVE_STAGE = 3,
    parameter int LOAD_LAT      = 1,
    parameter int FWD_EN        = 1,
    parameter int CNT_W         = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ihit,
    input  logic               dmem_req,
    input  logic               dhit,
    input  logic               dec_valid,
    input  logic [REG_W-1:0]   dec_rs,
    input  logic [REG_W-1:0]   dec_rt,
    input  logic               dec_rs_used,
    input  logic               dec_rt_used,
    input  logic               dec_wr_en,
    input  logic [REG_W-1:0]   dec_wr_reg,
    input  logic               dec_is_load,
    input  logic               dec_branch,
    input  logic               dec_jump,
    input  logic               dec_jr,
    input  logic               mispredict,
    output logic               enable_pc,
    output logic [STAGES-2:0]  enable_lat,
    output logic [STAGES-2:0]  flush_lat,
    output pc_sel_t            pc_sel,
    output logic [CNT_W-1:0]   stall_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    hz_state_t         state;
    logic              freeze;
    logic              mispred_act;
    logic              stall;
    logic              shift;
    logic              ins_valid;
    logic [STAGES-3:0] block_vec;

    assign freeze      = (dmem_req & ~dhit) | ~ihit;
    assign mispred_act = mispredict & ~freeze & ~RST;
    assign stall       = dec_valid & (|block_vec) & ~freeze & ~RST & ~mispredict;
    // Latches from ID/EX onward keep moving during a load-use stall (a bubble
    // enters EX), so the shadow pipe advances on every unfrozen cycle.
    assign shift       = ~freeze & ~RST;
    assign ins_valid   = dec_valid & dec_wr_en & (dec_wr_reg != '0) & ~stall & ~mispred_act;

    hazard_shadow_pipe #(
        .STAGES        (STAGES),
        .RESOLVE_STAGE (RESOLVE_STAGE),
        .LOAD_LAT      (LOAD_LAT),
        .FWD_EN        (FWD_EN)
    ) u_shadow (
        .CLK         (CLK),
        .RST         (RST),
        .shift       (shift),
        .kill        (mispred_act),
        .ins_valid   (ins_valid),
        .ins_reg     (dec_wr_reg),
        .ins_is_load (dec_is_load),
        .rs          (dec_rs),
        .rt          (dec_rt),
        .rs_used     (dec_rs_used),
        .rt_used     (dec_rt_used),
        .block_vec   (block_vec)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= HZ_RUN;
        end else begin
            case (state)
                HZ_RUN: begin
                    if (dmem_req && !dhit) state <= HZ_DSTALL;
                    else if (!ihit)        state <= HZ_ISTALL;
                end
                HZ_DSTALL: begin
                    if (dhit) state <= ihit ? HZ_RUN : HZ_ISTALL;
                end
                HZ_ISTALL: begin
                    if (ihit && (!dmem_req || dhit)) state <= HZ_RUN;
                end
                default: state <= HZ_RUN;
            endcase
        end
    end

    always_comb begin
        enable_pc  = 1'b1;
        enable_lat = '1;
        flush_lat  = '0;
        pc_sel     = SEL_NXT;
        if (RST) begin
            enable_pc  = 1'b0;
            enable_lat = '0;
            flush_lat  = '1;
        end else if (freeze) begin
            enable_pc  = 1'b0;
            enable_lat = '0;
        end else if (mispredict) begin
            pc_sel = SEL_RESOLVE;
            for (int i = 0; i < RESOLVE_STAGE; i++) flush_lat[i] = 1'b1;
        end else if (stall) begin
            enable_pc     = 1'b0;
            enable_lat[0] = 1'b0;
            flush_lat[1]  = 1'b1;
        end else if (dec_jump) begin
            pc_sel       = SEL_JMP;
            flush_lat[0] = 1'b1;
        end else if (dec_jr) begin
            pc_sel       = SEL_JR;
            flush_lat[0] = 1'b1;
        end else if (dec_branch) begin
            pc_sel       = SEL_BR_TGT;
            flush_lat[0] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)                                  stall_count <= '0;
        else if (!enable_pc && stall_count != '1) stall_count <= stall_count + CNT_ONE;
    end

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Directed bench for hazard_ctrl_sb across four parameterisations sharing one stimulus.
module tb_hazard_ctrl_sb;
    import cpu_types_pkg::*;
    import data_path_muxs_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ihit, dmem_req, dhit, dec_valid;
    logic [4:0] dec_rs, dec_rt, dec_wr_reg;
    logic       dec_rs_used, dec_rt_used, dec_wr_en, dec_is_load;
    logic       dec_branch, dec_jump, dec_jr, mispredict;

    logic        d5_pc, dnf_pc, d7_pc, ds_pc;
    logic [3:0]  d5_lat, d5_fl, dnf_lat, dnf_fl, ds_lat, ds_fl;
    logic [5:0]  d7_lat, d7_fl;
    pc_sel_t     d5_sel, dnf_sel, d7_sel, ds_sel;
    logic [31:0] d5_cnt, dnf_cnt, d7_cnt;
    logic [1:0]  ds_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl_sb u_d5 (
        .CLK(clk), .RST(rst), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_wr_en(dec_wr_en),
        .dec_wr_reg(dec_wr_reg), .dec_is_load(dec_is_load), .dec_branch(dec_branch),
        .dec_jump(dec_jump), .dec_jr(dec_jr), .mispredict(mispredict),
        .enable_pc(d5_pc), .enable_lat(d5_lat), .flush_lat(d5_fl), .pc_sel(d5_sel),
        .stall_count(d5_cnt)
    );

    hazard_ctrl_sb #(.FWD_EN(0)) u_dnf (
        .CLK(clk), .RST(rst), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_wr_en(dec_wr_en),
        .dec_wr_reg(dec_wr_reg), .dec_is_load(dec_is_load), .dec_branch(dec_branch),
        .dec_jump(dec_jump), .dec_jr(dec_jr), .mispredict(mispredict),
        .enable_pc(dnf_pc), .enable_lat(dnf_lat), .flush_lat(dnf_fl), .pc_sel(dnf_sel),
        .stall_count(dnf_cnt)
    );

    hazard_ctrl_sb #(.STAGES(7), .RESOLVE_STAGE(4), .LOAD_LAT(2)) u_d7 (
        .CLK(clk), .RST(rst), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_wr_en(dec_wr_en),
        .dec_wr_reg(dec_wr_reg), .dec_is_load(dec_is_load), .dec_branch(dec_branch),
        .dec_jump(dec_jump), .dec_jr(dec_jr), .mispredict(mispredict),
        .enable_pc(d7_pc), .enable_lat(d7_lat), .flush_lat(d7_fl), .pc_sel(d7_sel),
        .stall_count(d7_cnt)
    );

    hazard_ctrl_sb #(.CNT_W(2)) u_ds (
        .CLK(clk), .RST(rst), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_wr_en(dec_wr_en),
        .dec_wr_reg(dec_wr_reg), .dec_is_load(dec_is_load), .dec_branch(dec_branch),
        .dec_jump(dec_jump), .dec_jr(dec_jr), .mispredict(mispredict),
        .enable_pc(ds_pc), .enable_lat(ds_lat), .flush_lat(ds_fl), .pc_sel(ds_sel),
        .stall_count(ds_cnt)
    );

    task tick;
        @(posedge clk);
        #1;
    endtask

    task idle;
        ihit = 1'b1; dmem_req = 1'b0; dhit = 1'b0; dec_valid = 1'b0;
        dec_rs = '0; dec_rt = '0; dec_rs_used = 1'b0; dec_rt_used = 1'b0;
        dec_wr_en = 1'b0; dec_wr_reg = '0; dec_is_load = 1'b0;
        dec_branch = 1'b0; dec_jump = 1'b0; dec_jr = 1'b0; mispredict = 1'b0;
    endtask

    task set_dec(input logic [4:0] rs, input logic rs_u, input logic [4:0] rt, input logic rt_u,
                 input logic wr, input logic [4:0] wd, input logic ld);
        idle();
        dec_valid = 1'b1; dec_rs = rs; dec_rs_used = rs_u; dec_rt = rt; dec_rt_used = rt_u;
        dec_wr_en = wr; dec_wr_reg = wd; dec_is_load = ld;
    endtask

    task do_reset;
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task test_reset;
        idle();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({d5_pc, d5_lat, d5_fl, d5_sel} !== {1'b0, 4'h0, 4'hf, SEL_NXT}) begin
            n_bad++; $display("[TB] FAIL reset_outs: got %b want %b", {d5_pc, d5_lat, d5_fl, d5_sel}, {1'b0, 4'h0, 4'hf, SEL_NXT}); end
        n_cmp++; if (d7_fl !== 6'h3f) begin
            n_bad++; $display("[TB] FAIL reset_flush7: got %b want %b", d7_fl, 6'h3f); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (d5_cnt !== 32'd0 || d5_pc !== 1'b1) begin
            n_bad++; $display("[TB] FAIL reset_cnt: got cnt=%0d pc=%b want cnt=0 pc=1", d5_cnt, d5_pc); end
        tick();
    endtask

    task test_load_use;
        do_reset();
        set_dec(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1);
        @(negedge clk);
        n_cmp++; if (d5_pc !== 1'b1) begin
            n_bad++; $display("[TB] FAIL lu_lw_pc: got %b want 1", d5_pc); end
        tick();
        set_dec(5'd2, 1'b1, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0);
        @(negedge clk);
        n_cmp++; if ({d5_pc, d5_lat, d5_fl, d5_sel} !== {1'b0, 4'b1110, 4'b0010, SEL_NXT}) begin
            n_bad++; $display("[TB] FAIL lu_stall: got %b want %b", {d5_pc, d5_lat, d5_fl, d5_sel}, {1'b0, 4'b1110, 4'b0010, SEL_NXT}); end
        tick();
        @(negedge clk);
        n_cmp++; if ({d5_pc, d5_lat, d5_fl} !== {1'b1, 4'b1111, 4'b0000}) begin
            n_bad++; $display("[TB] FAIL lu_release: got %b want %b", {d5_pc, d5_lat, d5_fl}, {1'b1, 4'b1111, 4'b0000}); end
        n_cmp++; if (d5_cnt !== 32'd1) begin
            n_bad++; $display("[TB] FAIL lu_count: got %0d want 1", d5_cnt); end
        tick();
    endtask

    task test_no_fwd;
        do_reset();
        set_dec(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        tick();
        set_dec(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);
        @(negedge clk);
        n_cmp++; if (dnf_pc !== 1'b0) begin
            n_bad++; $display("[TB] FAIL nf_stall1: got %b want 0", dnf_pc); end
        n_cmp++; if (d5_pc !== 1'b1) begin
            n_bad++; $display("[TB] FAIL fwd_alu_nostall: got %b want 1", d5_pc); end
        tick();
        @(negedge clk);
        n_cmp++; if (dnf_pc !== 1'b0) begin
            n_bad++; $display("[TB] FAIL nf_stall2: got %b want 0", dnf_pc); end
        tick();
        @(negedge clk);
        n_cmp++; if (dnf_pc !== 1'b1 || dnf_cnt !== 32'd2) begin
            n_bad++; $display("[TB] FAIL nf_release: got pc=%b cnt=%0d want pc=1 cnt=2", dnf_pc, dnf_cnt); end
        tick();
    endtask

    task test_redirect;
        do_reset();
        idle(); dec_valid = 1'b1; dec_jump = 1'b1; dec_jr = 1'b1; dec_branch = 1'b1;
        @(negedge clk);
        n_cmp++; if ({d5_pc, d5_fl, d5_sel} !== {1'b1, 4'b0001, SEL_JMP}) begin
            n_bad++; $display("[TB] FAIL rd_jmp: got %b want %b", {d5_pc, d5_fl, d5_sel}, {1'b1, 4'b0001, SEL_JMP}); end
        tick();
        dec_jump = 1'b0;
        @(negedge clk);
        n_cmp++; if ({d5_fl, d5_sel} !== {4'b0001, SEL_JR}) begin
            n_bad++; $display("[TB] FAIL rd_jr: got %b want %b", {d5_fl, d5_sel}, {4'b0001, SEL_JR}); end
        tick();
        dec_jr = 1'b0;
        @(negedge clk);
        n_cmp++; if ({d5_fl, d5_sel} !== {4'b0001, SEL_BR_TGT}) begin
            n_bad++; $display("[TB] FAIL rd_br: got %b want %b", {d5_fl, d5_sel}, {4'b0001, SEL_BR_TGT}); end
        tick();
        set_dec(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd31, 1'b1);
        tick();
        set_dec(5'd31, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0); dec_jr = 1'b1;
        @(negedge clk);
        n_cmp++; if ({d5_pc, d5_fl, d5_sel} !== {1'b0, 4'b0010, SEL_NXT}) begin
            n_bad++; $display("[TB] FAIL rd_jr_blocked: got %b want %b", {d5_pc, d5_fl, d5_sel}, {1'b0, 4'b0010, SEL_NXT}); end
        tick();
        @(negedge clk);
        n_cmp++; if ({d5_pc, d5_fl, d5_sel} !== {1'b1, 4'b0001, SEL_JR}) begin
            n_bad++; $display("[TB] FAIL rd_jr_after: got %b want %b", {d5_pc, d5_fl, d5_sel}, {1'b1, 4'b0001, SEL_JR}); end
        tick();
    endtask

    task test_mispredict;
        do_reset();
        set_dec(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
        tick();
        idle(); dec_valid = 1'b1; dec_jump = 1'b1; mispredict = 1'b1;
        @(negedge clk);
        n_cmp++; if ({d5_pc, d5_lat, d5_fl, d5_sel} !== {1'b1, 4'b1111, 4'b0111, SEL_RESOLVE}) begin
            n_bad++; $display("[TB] FAIL mp_d5: got %b want %b", {d5_pc, d5_lat, d5_fl, d5_sel}, {1'b1, 4'b1111, 4'b0111, SEL_RESOLVE}); end
        n_cmp++; if ({d7_fl, d7_sel} !== {6'b001111, SEL_RESOLVE}) begin
            n_bad++; $display("[TB] FAIL mp_d7: got %b want %b", {d7_fl, d7_sel}, {6'b001111, SEL_RESOLVE}); end
        tick();
        set_dec(5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        n_cmp++; if (dnf_pc !== 1'b1) begin
            n_bad++; $display("[TB] FAIL mp_slot1_killed: got %b want 1", dnf_pc); end
        tick();
    endtask

    task test_dstall;
        do_reset();
        idle(); dmem_req = 1'b1; dhit = 1'b0; mispredict = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if ({d5_pc, d5_lat, d5_fl, d5_sel} !== {1'b0, 4'h0, 4'h0, SEL_NXT}) begin
                n_bad++; $display("[TB] FAIL ds_frozen%0d: got %b want %b", i, {d5_pc, d5_lat, d5_fl, d5_sel}, {1'b0, 4'h0, 4'h0, SEL_NXT}); end
            if (i > 0) begin
                n_cmp++; if (u_d5.state !== HZ_DSTALL) begin
                    n_bad++; $display("[TB] FAIL ds_state%0d: got %0d want %0d", i, u_d5.state, HZ_DSTALL); end
            end
            tick();
        end
        dhit = 1'b1; ihit = 1'b1;
        @(negedge clk);
        n_cmp++; if ({d5_pc, d5_fl, d5_sel} !== {1'b1, 4'b0111, SEL_RESOLVE}) begin
            n_bad++; $display("[TB] FAIL ds_resume: got %b want %b", {d5_pc, d5_fl, d5_sel}, {1'b1, 4'b0111, SEL_RESOLVE}); end
        n_cmp++; if (d5_cnt !== 32'd4 || ds_cnt !== 2'd3) begin
            n_bad++; $display("[TB] FAIL ds_count: got %0d/%0d want 4/3", d5_cnt, ds_cnt); end
        tick();
        idle();
        @(negedge clk);
        n_cmp++; if (u_d5.state !== HZ_RUN) begin
            n_bad++; $display("[TB] FAIL ds_run: got %0d want %0d", u_d5.state, HZ_RUN); end
        tick();
    endtask

    task test_deep;
        do_reset();
        set_dec(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1);
        tick();
        set_dec(5'd2, 1'b1, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0);
        @(negedge clk);
        n_cmp++; if ({d7_pc, d7_lat, d7_fl} !== {1'b0, 6'b111110, 6'b000010}) begin
            n_bad++; $display("[TB] FAIL d7_stall1: got %b want %b", {d7_pc, d7_lat, d7_fl}, {1'b0, 6'b111110, 6'b000010}); end
        tick();
        @(negedge clk);
        n_cmp++; if (d7_pc !== 1'b0) begin
            n_bad++; $display("[TB] FAIL d7_stall2: got %b want 0", d7_pc); end
        tick();
        @(negedge clk);
        n_cmp++; if (d7_pc !== 1'b1 || d7_cnt !== 32'd2) begin
            n_bad++; $display("[TB] FAIL d7_release: got pc=%b cnt=%0d want pc=1 cnt=2", d7_pc, d7_cnt); end
        tick();
    endtask

    task test_reset_istall;
        do_reset();
        set_dec(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1);
        tick();
        idle(); ihit = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++; if (u_d5.state !== HZ_ISTALL) begin
            n_bad++; $display("[TB] FAIL ri_state: got %0d want %0d", u_d5.state, HZ_ISTALL); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({d5_pc, d5_fl} !== {1'b0, 4'hf}) begin
            n_bad++; $display("[TB] FAIL ri_flush: got %b want %b", {d5_pc, d5_fl}, {1'b0, 4'hf}); end
        tick();
        rst = 1'b0;
        set_dec(5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        n_cmp++; if (d5_pc !== 1'b1 || d5_cnt !== 32'd0 || u_d5.state !== HZ_RUN) begin
            n_bad++; $display("[TB] FAIL ri_cleared: got pc=%b cnt=%0d st=%0d want pc=1 cnt=0 st=0", d5_pc, d5_cnt, u_d5.state); end
        tick();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_no_fwd();
        test_redirect();
        test_mispredict();
        test_dstall();
        test_deep();
        test_reset_istall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
